graycounter_axil_regs: RTL

- AXI4-Lite slave register file and Gray-code counter core.
- Sits directly downstream of the AXI4-Lite master BFM: it consumes the master's write and read bursts on the S00_AXI port and returns OKAY responses.
- Exposes control, prescale, scratch and live Gray count registers.
- Drives the Gray count and a wrap pulse to fabric.

---
 rtl/graycounter_pkg.sv | 36 +++
 rtl/graycounter_core.sv | 54 +++++
 rtl/graycounter_axil_regs.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/graycounter_pkg.sv
// Shared constants, FSM encodings and helpers for the Gray counter register block.
package graycounter_pkg;

  // Word indices (addr[3:2])
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_SCRATCH  = 2'd2;
  localparam logic [1:0] REG_COUNT    = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;
  localparam int CTRL_CLR = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  // Binary to reflected Gray; callers zero-extend narrower counts.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Merge write data into a register honouring byte enables.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/graycounter_core.sv
// Prescaled binary up/down counter with registered Gray output and wrap pulse.
module graycounter_core
  import graycounter_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          dir,
  input  logic          clr,
  input  logic [31:0]   prescale,
  output logic [CW-1:0] gray_out,
  output logic          wrap_pulse
);

  logic [31:0]   div;
  logic [CW-1:0] bin;
  logic          tick;
  logic          at_wrap;

  // A tick fires once every prescale+1 enabled cycles.
  assign tick    = en && (div == prescale);
  // Next tick leaves the count range: all-ones going up, zero going down.
  assign at_wrap = dir ? (bin == '0) : (bin == '1);

  // Divider and binary count; a clear wins over a same-cycle tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      bin <= '0;
    end else if (clr) begin
      div <= '0;
      bin <= '0;
    end else if (tick) begin
      div <= '0;
      bin <= dir ? bin - 1'b1 : bin + 1'b1;
    end else if (en) begin
      div <= div + 32'd1;
    end
  end

  // Gray view trails the binary count by one cycle; wrap flags the wrapping tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_out   <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      gray_out   <= CW'(bin2gray(32'(bin)));
      wrap_pulse <= !clr && tick && at_wrap;
    end
  end

endmodule

// File: rtl/graycounter_axil_regs.sv
// AXI4-Lite register file (CTRL/PRESCALE/SCRATCH/COUNT) around the Gray counter core.
module graycounter_axil_regs
  import graycounter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_COUNT_WIDTH      = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_COUNT_WIDTH-1:0]        gray_out,
  output logic                            wrap_pulse
);

  wr_state_t   wr_state, wr_next;
  rd_state_t   rd_state, rd_next;
  logic        wr_go, rd_go;
  logic [1:0]  wr_idx, rd_idx;
  logic        ctrl_en, ctrl_dir, clr;
  logic [31:0] prescale, scratch, rd_mux;
  logic        unused;

  assign wr_idx = s00_axi_awaddr[3:2];
  assign rd_idx = s00_axi_araddr[3:2];
  assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                    s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write FSM state register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) wr_state <= W_IDLE;
    else                  wr_state <= wr_next;
  end

  // Write FSM: accept AW and W only together, then hold B until taken.
  always_comb begin
    wr_next = wr_state;
    wr_go   = 1'b0;
    case (wr_state)
      W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) begin
        wr_go   = 1'b1;
        wr_next = W_RESP;
      end
      W_RESP: if (s00_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  assign s00_axi_awready = wr_go;
  assign s00_axi_wready  = wr_go;
  assign s00_axi_bvalid  = (wr_state == W_RESP);
  assign s00_axi_bresp   = RESP_OKAY;

  // CLR is a strobe on the accepting edge only; it is never stored.
  assign clr = wr_go && (wr_idx == REG_CTRL) && s00_axi_wstrb[0] &&
               s00_axi_wdata[CTRL_CLR];

  // Register updates on the joint AW/W handshake edge; COUNT writes are dropped.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl_en  <= 1'b0;
      ctrl_dir <= 1'b0;
      prescale <= '0;
      scratch  <= '0;
    end else if (wr_go) begin
      case (wr_idx)
        REG_CTRL: if (s00_axi_wstrb[0]) begin
          ctrl_en  <= s00_axi_wdata[CTRL_EN];
          ctrl_dir <= s00_axi_wdata[CTRL_DIR];
        end
        REG_PRESCALE: prescale <= apply_wstrb(prescale, s00_axi_wdata, s00_axi_wstrb);
        REG_SCRATCH:  scratch  <= apply_wstrb(scratch, s00_axi_wdata, s00_axi_wstrb);
        default: ;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) rd_state <= R_IDLE;
    else                  rd_state <= rd_next;
  end

  // Read FSM: one-cycle AR accept, then hold R until taken.
  always_comb begin
    rd_next = rd_state;
    rd_go   = 1'b0;
    case (rd_state)
      R_IDLE: if (s00_axi_arvalid) begin
        rd_go   = 1'b1;
        rd_next = R_DATA;
      end
      R_DATA: if (s00_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  assign s00_axi_arready = rd_go;
  assign s00_axi_rvalid  = (rd_state == R_DATA);
  assign s00_axi_rresp   = RESP_OKAY;

  // Read mux; sampling pre-edge values gives read-before-write on collisions.
  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_CTRL:     rd_mux = {30'd0, ctrl_dir, ctrl_en};
      REG_PRESCALE: rd_mux = prescale;
      REG_SCRATCH:  rd_mux = scratch;
      REG_COUNT:    rd_mux = 32'(gray_out);
      default:      rd_mux = '0;
    endcase
  end

  // Capture read data on the AR handshake; it stays stable while rvalid waits.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) s00_axi_rdata <= '0;
    else if (rd_go)       s00_axi_rdata <= rd_mux;
  end

  graycounter_core #(.CW(C_COUNT_WIDTH)) u_core (
    .clk        (s00_axi_aclk),
    .rst_n      (s00_axi_aresetn),
    .en         (ctrl_en),
    .dir        (ctrl_dir),
    .clr        (clr),
    .prescale   (prescale),
    .gray_out   (gray_out),
    .wrap_pulse (wrap_pulse)
  );

endmodule
